fp_status_monitor: RTL
======================

FP_STATUS_MONITOR -- requirements
Module: fp_status_monitor

Interface
REQ-001 The block SHALL have parameter EXP_W, default 8, meaning exponent width of a, b and z.
REQ-002 The block SHALL have parameter MAN_W, default 23, meaning mantissa width; operand width W = 1+EXP_W+MAN_W.
REQ-003 The block SHALL have parameter LATENCY, default 3, legal range 1..8, meaning multiplier pipeline depth between operands and z/status.
REQ-004 The block SHALL have parameter CNT_W, default 16, meaning error counter width.
REQ-005 The block SHALL use port clk, input, 1 bit, as its single clock; all state updates on rising edge.
REQ-006 The block SHALL use port rst_n, input, 1 bit, as an asynchronous active-low reset.
REQ-007 Port in_valid, input, 1: a/b carry a valid operand pair this cycle.
REQ-008 Ports a, b, input, W: multiplier operands.
REQ-009 Port z, input, W: multiplier result, aligned with status_bits.
REQ-010 Port status_bits, input, 8: bit0 ZERO, bit1 INF, bit2 NAN, bit3 TINY, bit4 HUGE; bits 7:5 ignored.
REQ-011 Port check_en, input, 5: per-check enable mask, same bit order.
REQ-012 Port clear, input, 1: synchronous clear of sticky, count and first-error state.
REQ-013 Port err_vec, output, 5: per-check failure pulse, registered.
REQ-014 Port err_sticky, output, 5: accumulated failures since reset/clear.
REQ-015 Port err_count, output, CNT_W: number of cycles with at least one recorded failure, saturating.
REQ-016 Ports first_err_valid, output, 1, and first_err_id, output, 3: index of first recorded failure.

Function
REQ-017 History: a LATENCY-deep shift register SHALL shift every cycle, storing {in_valid, a exponent, b exponent}; stage LATENCY-1 is the pair from exactly LATENCY cycles earlier.
REQ-018 Checks SHALL be evaluated combinationally each cycle on current z/status_bits and history tail; a check fails only if its status bit is 1 and its check_en bit is 1.
REQ-019 ZERO SHALL fail when z exponent != all-zeros.
REQ-020 INF SHALL fail when z exponent != all-ones.
REQ-021 NAN SHALL fail when history tail valid is 1 and NOT ((exp_a==0 and exp_b==all-ones) or (exp_a==all-ones and exp_b==0)); when tail valid is 0 the NAN check SHALL be skipped (no failure).
REQ-022 TINY SHALL fail unless z exponent==0, or z exponent==1 with mantissa==0.
REQ-023 HUGE SHALL fail unless z exponent==all-ones, or z exponent==all-ones minus 1 with mantissa all-ones.
REQ-024 err_vec SHALL present the cycle-N failure vector at cycle N+1 (latency 1) and hold for exactly one cycle.
REQ-025 On a cycle with any failure and clear=0: err_sticky |= failures; err_count += 1 unless already all-ones (saturates, no wrap).
REQ-026 If first_err_valid=0 and failures present with clear=0, first_err_id SHALL take the lowest failing index and first_err_valid SHALL become 1; both hold until clear or reset.
REQ-027 clear=1 SHALL zero err_sticky, err_count, first_err_valid, first_err_id next edge; same-cycle failures SHALL be discarded from these but still appear on err_vec.
REQ-028 Multiple simultaneous failures SHALL increment err_count by exactly 1.
REQ-029 clear SHALL NOT affect the history register.

Reset
REQ-030 While rst_n=0, all history stages (including valid bits), err_vec, err_sticky, err_count, first_err_valid and first_err_id SHALL be 0, independent of clk.
REQ-031 After rst_n deasserts, NAN checks SHALL be skipped until LATENCY cycles of history with in_valid=1 have propagated.
REQ-032 Reset asserted mid-operation SHALL discard in-flight history; no failure from pre-reset data SHALL appear after release.

Verification
REQ-033 Defaults, check_en=5'h1F: status=ZERO with z exp 8'h00 -> err_vec=0; z exp 8'h05 -> err_vec=5'b00001 next cycle, err_count=1, first_err_id=0.
REQ-034 Drive a exp 8'h00, b exp 8'hFF, in_valid=1 at cycle 0; status NAN at cycle 3 -> no failure; same with b exp 8'h80 -> err_vec bit2 at cycle 4.
REQ-035 HUGE with z=32'h7F7FFFFF -> pass; z=32'h7F7FFFFE -> fail; TINY with z=32'h00800000 -> pass, 32'h00800001 -> fail.
REQ-036 CNT_W=2, force failures 5 consecutive cycles -> err_count 1,2,3,3,3; failure with clear=1 -> count 0, err_vec still pulses.
REQ-037 Status 5'b10011 with z exp 8'h05 in one cycle -> err_vec=5'b10011, count +1, first_err_id=0; check_en=0 -> no failures.
REQ-038 Assert rst_n=0 mid-stream with pending NAN history -> outputs 0 immediately; after release, NAN asserted within LATENCY cycles -> no failure.

Source files
------------

// File: rtl/fp_status_monitor.sv
// fp_status_monitor: cross-checks a floating-point multiplier's status flags
// against its result exponent/mantissa and the operand exponents seen LATENCY
// cycles earlier. Reports per-check failure pulses, sticky flags, a saturating
// failure-cycle counter and the index of the first recorded failure.
module fp_status_monitor #(
    parameter int EXP_W   = 8,
    parameter int MAN_W   = 23,
    parameter int LATENCY = 3,
    parameter int CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    input  logic [EXP_W+MAN_W:0]   z,
    input  logic [7:0]             status_bits,
    input  logic [4:0]             check_en,
    input  logic                   clear,
    output logic [4:0]             err_vec,
    output logic [4:0]             err_sticky,
    output logic [CNT_W-1:0]       err_count,
    output logic                   first_err_valid,
    output logic [2:0]             first_err_id
);

    localparam int W = 1 + EXP_W + MAN_W;
    localparam logic [EXP_W-1:0] EXP_ZERO = '0;
    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [EXP_W-1:0] EXP_ONE  = EXP_W'(1);
    localparam logic [EXP_W-1:0] EXP_MAXN = EXP_ONES - EXP_ONE;
    localparam logic [MAN_W-1:0] MAN_ONES = '1;

    logic [EXP_W-1:0] exp_a, exp_b, exp_z;
    logic [MAN_W-1:0] man_z;

    assign exp_a = a[W-2:MAN_W];
    assign exp_b = b[W-2:MAN_W];
    assign exp_z = z[W-2:MAN_W];
    assign man_z = z[MAN_W-1:0];

    // Signs, operand mantissas and the reserved status bits play no part in any check.
    logic unused_bits;
    assign unused_bits = ^{a[W-1], a[MAN_W-1:0], b[W-1], b[MAN_W-1:0], z[W-1], status_bits[7:5]};

    // Operand-exponent history, aligned with the multiplier pipeline
    logic [LATENCY-1:0]            hv_q, hv_d;
    logic [LATENCY-1:0][EXP_W-1:0] ha_q, ha_d;
    logic [LATENCY-1:0][EXP_W-1:0] hb_q, hb_d;

    // Shift the history by one stage every cycle; stage 0 takes the current pair
    always_comb begin
        hv_d    = hv_q;
        ha_d    = ha_q;
        hb_d    = hb_q;
        hv_d[0] = in_valid;
        ha_d[0] = exp_a;
        hb_d[0] = exp_b;
        for (int i = 1; i < LATENCY; i++) begin
            hv_d[i] = hv_q[i-1];
            ha_d[i] = ha_q[i-1];
            hb_d[i] = hb_q[i-1];
        end
    end

    // History register; reset drops in-flight pairs, clear deliberately does not touch it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hv_q <= '0;
            ha_q <= '0;
            hb_q <= '0;
        end else begin
            hv_q <= hv_d;
            ha_q <= ha_d;
            hb_q <= hb_d;
        end
    end

    logic            tail_v;
    logic [EXP_W-1:0] tail_a, tail_b;
    logic [4:0]      ok;
    logic [4:0]      fail;

    assign tail_v = hv_q[LATENCY-1];
    assign tail_a = ha_q[LATENCY-1];
    assign tail_b = hb_q[LATENCY-1];

    // Evaluate each flag's consistency rule; a flag fails only when raised and enabled
    always_comb begin
        ok[0] = (exp_z == EXP_ZERO);
        ok[1] = (exp_z == EXP_ONES);
        ok[2] = !tail_v
              || ((tail_a == EXP_ZERO) && (tail_b == EXP_ONES))
              || ((tail_a == EXP_ONES) && (tail_b == EXP_ZERO));
        ok[3] = (exp_z == EXP_ZERO) || ((exp_z == EXP_ONE) && (man_z == '0));
        ok[4] = (exp_z == EXP_ONES) || ((exp_z == EXP_MAXN) && (man_z == MAN_ONES));
        fail  = status_bits[4:0] & check_en & ~ok;
    end

    logic [4:0]       err_vec_q;
    logic [4:0]       sticky_q, sticky_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             fvalid_q, fvalid_d;
    logic [2:0]       fid_q, fid_d;
    logic [2:0]       low_id;

    // Lowest-index failing check
    always_comb begin
        low_id = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (fail[i]) low_id = 3'(i);
        end
    end

    // Accumulated state: clear wins and discards same-cycle failures
    always_comb begin
        sticky_d = sticky_q;
        count_d  = count_q;
        fvalid_d = fvalid_q;
        fid_d    = fid_q;
        if (clear) begin
            sticky_d = '0;
            count_d  = '0;
            fvalid_d = 1'b0;
            fid_d    = 3'd0;
        end else if (fail != 5'd0) begin
            sticky_d = sticky_q | fail;
            if (count_q != '1) count_d = count_q + CNT_W'(1);
            if (!fvalid_q) begin
                fvalid_d = 1'b1;
                fid_d    = low_id;
            end
        end
    end

    // Register the failure pulse and the accumulated error state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_vec_q <= '0;
            sticky_q  <= '0;
            count_q   <= '0;
            fvalid_q  <= 1'b0;
            fid_q     <= 3'd0;
        end else begin
            err_vec_q <= fail;
            sticky_q  <= sticky_d;
            count_q   <= count_d;
            fvalid_q  <= fvalid_d;
            fid_q     <= fid_d;
        end
    end

    assign err_vec         = err_vec_q;
    assign err_sticky      = sticky_q;
    assign err_count       = count_q;
    assign first_err_valid = fvalid_q;
    assign first_err_id    = fid_q;

endmodule
